// File: rtl/noise_channel_if.sv
// noise_channel_if: register-file / frame-sequencer side of the noise channel
// plus the sample and status outputs toward the mixer and $4015 read path.
//
// Signalling: every input strobe (enable_240hz, enable_120hz, reg_event) is a
// one-clk-wide qualifier sampled on the rising clk edge. There is no
// backpressure; the channel always accepts a strobe in the cycle it is high.
// Register bytes are level inputs and are read in the same cycle as a strobe.
interface noise_channel_if;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       channel_enable;
  logic [7:0] reg_400C;
  logic [7:0] reg_400E;
  logic [7:0] reg_400F;
  logic       reg_event;
  logic [3:0] noise_data;
  logic       length_active;

  modport master (
    output enable_240hz, enable_120hz, channel_enable,
    output reg_400C, reg_400E, reg_400F, reg_event,
    input  noise_data, length_active
  );

  modport slave (
    input  enable_240hz, enable_120hz, channel_enable,
    input  reg_400C, reg_400E, reg_400F, reg_event,
    output noise_data, length_active
  );
endinterface

// File: rtl/noise_channel_gen.sv
// noise_channel_gen: APU noise channel. Prescaled period timer clocks an LFSR;
// a length counter gates the output; volume comes from the constant-volume
// field or the envelope decay unit.
// Optional feature macro: NOISE_ENVELOPE_EN builds the envelope decay unit.
// Without it the volume is always reg_400C[3:0].
module noise_channel_gen #(
  parameter int LFSR_WIDTH = 15,
  parameter int SHORT_TAP  = 6,
  parameter int CLK_DIV    = 1
) (
  input logic           clk,
  input logic           rst,
  noise_channel_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0]         presc;
  logic                  tick;
  logic [11:0]           timer;
  logic                  timer_event;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic                  feedback;
  logic [7:0]            length_cnt;
  logic [3:0]            volume;
  logic [3:0]            noise_q;
  logic                  unused_bits;

  function automatic logic [11:0] period_lut(input logic [3:0] sel);
    logic [11:0] p;
    case (sel)
      4'd0:    p = 12'h004;
      4'd1:    p = 12'h008;
      4'd2:    p = 12'h010;
      4'd3:    p = 12'h020;
      4'd4:    p = 12'h040;
      4'd5:    p = 12'h060;
      4'd6:    p = 12'h080;
      4'd7:    p = 12'h0A0;
      4'd8:    p = 12'h0CA;
      4'd9:    p = 12'h0FE;
      4'd10:   p = 12'h17C;
      4'd11:   p = 12'h1FC;
      4'd12:   p = 12'h2FA;
      4'd13:   p = 12'h3F8;
      4'd14:   p = 12'h7F2;
      default: p = 12'hFE4;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] length_lut(input logic [4:0] sel);
    logic [7:0] l;
    case (sel)
      5'd0:  l = 8'h0A; 5'd1:  l = 8'hFE; 5'd2:  l = 8'h14; 5'd3:  l = 8'h02;
      5'd4:  l = 8'h28; 5'd5:  l = 8'h04; 5'd6:  l = 8'h50; 5'd7:  l = 8'h06;
      5'd8:  l = 8'hA0; 5'd9:  l = 8'h08; 5'd10: l = 8'h3C; 5'd11: l = 8'h0A;
      5'd12: l = 8'h0E; 5'd13: l = 8'h0C; 5'd14: l = 8'h1A; 5'd15: l = 8'h0E;
      5'd16: l = 8'h0C; 5'd17: l = 8'h10; 5'd18: l = 8'h18; 5'd19: l = 8'h12;
      5'd20: l = 8'h30; 5'd21: l = 8'h14; 5'd22: l = 8'h60; 5'd23: l = 8'h16;
      5'd24: l = 8'hC0; 5'd25: l = 8'h18; 5'd26: l = 8'h48; 5'd27: l = 8'h1A;
      5'd28: l = 8'h10; 5'd29: l = 8'h1C; 5'd30: l = 8'h20; default: l = 8'h1E;
    endcase
    return l;
  endfunction

  assign tick     = (presc == PW'(CLK_DIV - 1));
  assign feedback = lfsr[0] ^ (bus.reg_400E[7] ? lfsr[SHORT_TAP] : lfsr[1]);

  // Prescaler: one timer tick every CLK_DIV system clocks.
  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  // Period timer: reload on zero so a new period select only lands at reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= 12'd0;
      timer_event <= 1'b0;
    end else begin
      timer_event <= tick && (timer == 12'd0);
      if (tick) begin
        if (timer == 12'd0) timer <= period_lut(bus.reg_400E[3:0]);
        else                timer <= timer - 12'd1;
      end
    end
  end

  // LFSR: shift on timer_event; an all-zero state is recovered by reloading 1.
  always_ff @(posedge clk) begin
    if (rst)                lfsr <= LFSR_WIDTH'(1);
    else if (lfsr == '0)    lfsr <= LFSR_WIDTH'(1);
    else if (timer_event)   lfsr <= {feedback, lfsr[LFSR_WIDTH-1:1]};
  end

  // Length counter: channel disable wins, then a $400F load, then half-frame decrement.
  always_ff @(posedge clk) begin
    if (rst)                      length_cnt <= 8'd0;
    else if (!bus.channel_enable) length_cnt <= 8'd0;
    else if (bus.reg_event)       length_cnt <= length_lut(bus.reg_400F[7:3]);
    else if (bus.enable_120hz && (length_cnt != 8'd0) && !bus.reg_400C[5])
      length_cnt <= length_cnt - 8'd1;
  end

`ifdef NOISE_ENVELOPE_EN
  logic       start_flag;
  logic [3:0] divider;
  logic [3:0] decay;

  // Envelope: a $400F write arms a restart that the next quarter-frame performs.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_flag <= 1'b0;
      divider    <= 4'd0;
      decay      <= 4'd0;
    end else if (bus.reg_event) begin
      start_flag <= 1'b1;
    end else if (bus.enable_240hz) begin
      if (start_flag) begin
        start_flag <= 1'b0;
        decay      <= 4'd15;
        divider    <= bus.reg_400C[3:0];
      end else if (divider == 4'd0) begin
        divider <= bus.reg_400C[3:0];
        if (decay != 4'd0)       decay <= decay - 4'd1;
        else if (bus.reg_400C[5]) decay <= 4'd15;
      end else begin
        divider <= divider - 4'd1;
      end
    end
  end

  assign volume      = bus.reg_400C[4] ? bus.reg_400C[3:0] : decay;
  assign unused_bits = ^{bus.reg_400C[7:6], bus.reg_400E[6:4], bus.reg_400F[2:0]};
`else
  assign volume      = bus.reg_400C[3:0];
  assign unused_bits = ^{bus.reg_400C[7:6], bus.reg_400C[4], bus.reg_400E[6:4],
                         bus.reg_400F[2:0], bus.enable_240hz};
`endif

  // Output sample: silent when the length counter has expired or LFSR bit0 is set.
  always_ff @(posedge clk) begin
    if (rst)                                   noise_q <= 4'd0;
    else if ((length_cnt == 8'd0) || lfsr[0])  noise_q <= 4'd0;
    else                                       noise_q <= volume;
  end

  assign bus.noise_data    = noise_q;
  assign bus.length_active = (length_cnt != 8'd0);

endmodule

// File: tb/tb_noise_channel_gen.sv
// tb_noise_channel_gen: directed bench for noise_channel_gen (default
// parameters plus a CLK_DIV=3 instance). Envelope checks are compiled when
// NOISE_ENVELOPE_EN is defined.
module tb_noise_channel_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   first_ret;
  logic [14:0] exp_q[$];
  logic [14:0] model;

`ifdef NOISE_ENVELOPE_EN
  localparam logic [3:0] VOL5 = 4'd0;
`else
  localparam logic [3:0] VOL5 = 4'd5;
`endif

  noise_channel_if if1 ();
  noise_channel_if if3 ();

  noise_channel_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  noise_channel_gen #(.CLK_DIV(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse_reg_event(input logic [7:0] v);
    if1.reg_400F  = v;
    if1.reg_event = 1'b1;
    tick(1);
    if1.reg_event = 1'b0;
  endtask

  task automatic pulse_120();
    if1.enable_120hz = 1'b1;
    tick(1);
    if1.enable_120hz = 1'b0;
    tick(1);
  endtask

  task automatic pulse_240();
    if1.enable_240hz = 1'b1;
    tick(1);
    if1.enable_240hz = 1'b0;
    tick(1);
  endtask

  // Advance until the chosen instance shows timer_event, bounded by limit clks.
  task automatic wait_event(input bit on3, input int limit, input string tag, output int cnt);
    logic ev;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      ev = on3 ? dut3.timer_event : dut.timer_event;
    end while (!ev && cnt < limit);
    check({tag, "_seen"}, 32'(ev), 32'd1);
  endtask

  // Wait for a timer_event and then the clk in which the LFSR shifts.
  task automatic shift_once(input string tag, output int cnt);
    wait_event(1'b0, 50, tag, cnt);
    tick(1);
    cnt++;
  endtask

  function automatic logic [14:0] step(input logic [14:0] s, input logic m);
    return {s[0] ^ (m ? s[6] : s[1]), s[14:1]};
  endfunction

  initial begin
    rst = 1'b1;
    if1.enable_240hz = 0; if1.enable_120hz = 0; if1.channel_enable = 1;
    if1.reg_400C = 0; if1.reg_400E = 0; if1.reg_400F = 0; if1.reg_event = 0;
    if3.enable_240hz = 0; if3.enable_120hz = 0; if3.channel_enable = 0;
    if3.reg_400C = 0; if3.reg_400E = 0; if3.reg_400F = 0; if3.reg_event = 0;
    tick(3);
    check("reset_noise", 32'(if1.noise_data), 32'd0);
    check("reset_active", 32'(if1.length_active), 32'd0);
    check("reset_lfsr", 32'(dut.lfsr), 32'd1);
    check("reset_timer_event", 32'(dut.timer_event), 32'd0);
    check("reset_length", 32'(dut.length_cnt), 32'd0);
    rst = 1'b0;

    // Long mode: hand-derived first 16 states from seed 1
    for (int k = 0; k < 14; k++) exp_q.push_back(15'h4000 >> k);
    exp_q.push_back(15'h4001);
    exp_q.push_back(15'h6000);

    shift_once("first_shift", n);
    check("first_shift_latency", n, 32'd2);
    check("lfsr_shift1", 32'(dut.lfsr), 32'(exp_q.pop_front()));

    if1.reg_400C = 8'h19;
    pulse_reg_event(8'h08);
    check("load_length_fe", 32'(dut.length_cnt), 32'hFE);
    check("length_active_rise", 32'(if1.length_active), 32'd1);
    tick(1);
    check("noise_vol9", 32'(if1.noise_data), 32'd9);

    for (int k = 2; k <= 16; k++) begin
      shift_once("long_shift", n);
      if (k >= 3 && k != 16) check("shift_period_5", n, 32'd5);
      check("lfsr_long", 32'(dut.lfsr), 32'(exp_q.pop_front()));
      if (k == 15) begin
        tick(1);
        check("noise_bit0_high", 32'(if1.noise_data), 32'd0);
      end
    end
    tick(1);
    check("noise_after_6000", 32'(if1.noise_data), 32'd9);

    // Continue against a reference model; switch volume and then mode mid-run
    model = 15'h6000;
    for (int k = 17; k <= 46; k++) begin
      if (k == 32) if1.reg_400C = 8'h05;
      if (k == 40) if1.reg_400E = 8'h80;
      model = step(model, if1.reg_400E[7]);
      exp_q.push_back(model);
      shift_once("model_shift", n);
      check("lfsr_model", 32'(dut.lfsr), 32'(exp_q.pop_front()));
      tick(1);
      check("noise_model", 32'(if1.noise_data), model[0] ? 32'd0 : (k >= 32 ? 32'(VOL5) : 32'd9));
    end

    // Reset coincident with every strobe
    rst = 1'b1;
    if1.reg_event = 1; if1.enable_120hz = 1; if1.enable_240hz = 1; if1.reg_400F = 8'h08;
    tick(1);
    if1.reg_event = 0; if1.enable_120hz = 0; if1.enable_240hz = 0;
    check("midreset_length", 32'(dut.length_cnt), 32'd0);
    check("midreset_active", 32'(if1.length_active), 32'd0);
    check("midreset_lfsr", 32'(dut.lfsr), 32'd1);
    check("midreset_noise", 32'(if1.noise_data), 32'd0);
    tick(1);
    rst = 1'b0;

    // Short mode period from seed 1
    first_ret = 0;
    for (int k = 1; k <= 120 && first_ret == 0; k++) begin
      shift_once("short_shift", n);
      if (dut.lfsr == 15'd1) first_ret = k;
    end
    check("short_period_93", first_ret, 32'd93);

    // Length counter
    if1.reg_400E = 8'h00;
    if1.reg_400C = 8'h05;
    pulse_reg_event(8'h08);
    check("len_load_fe", 32'(dut.length_cnt), 32'hFE);
    repeat (253) pulse_120();
    check("len_after_253", 32'(dut.length_cnt), 32'd1);
    check("active_after_253", 32'(if1.length_active), 32'd1);
    pulse_120();
    check("len_after_254", 32'(dut.length_cnt), 32'd0);
    check("active_after_254", 32'(if1.length_active), 32'd0);
    pulse_120();
    check("len_no_wrap", 32'(dut.length_cnt), 32'd0);
    pulse_reg_event(8'hF8);
    check("len_load_1e", 32'(dut.length_cnt), 32'h1E);
    pulse_reg_event(8'h30);
    check("len_load_50", 32'(dut.length_cnt), 32'h50);
    pulse_reg_event(8'h00);
    check("len_load_0a", 32'(dut.length_cnt), 32'h0A);
    if1.reg_400C = 8'h25;
    pulse_120();
    check("len_halt", 32'(dut.length_cnt), 32'h0A);
    if1.reg_400C = 8'h05;
    repeat (3) pulse_120();
    check("len_dec3", 32'(dut.length_cnt), 32'h07);
    if1.reg_400F = 8'h18; if1.reg_event = 1; if1.enable_120hz = 1;
    tick(1);
    if1.reg_event = 0; if1.enable_120hz = 0;
    check("len_load_beats_dec", 32'(dut.length_cnt), 32'h02);
    if1.channel_enable = 0;
    tick(1);
    check("disable_len", 32'(dut.length_cnt), 32'd0);
    check("disable_active", 32'(if1.length_active), 32'd0);
    tick(1);
    check("disable_noise", 32'(if1.noise_data), 32'd0);
    pulse_reg_event(8'h08);
    check("disabled_load_ignored", 32'(dut.length_cnt), 32'd0);
    check("disabled_active", 32'(if1.length_active), 32'd0);
    if1.channel_enable = 1;

`ifdef NOISE_ENVELOPE_EN
    // Envelope decay, hold, loop and restart timing
    apply_reset();
    if1.reg_400C = 8'h00;
    pulse_reg_event(8'h08);
    check("env_start_set", 32'(dut.start_flag), 32'd1);
    check("env_decay_idle", 32'(dut.decay), 32'd0);
    pulse_240();
    check("env_restart15", 32'(dut.decay), 32'd15);
    check("env_start_clr", 32'(dut.start_flag), 32'd0);
    for (int d = 14; d >= 0; d--) begin
      pulse_240();
      check("env_decay", 32'(dut.decay), 32'(d));
    end
    pulse_240();
    check("env_hold0", 32'(dut.decay), 32'd0);
    if1.reg_400C = 8'h20;
    pulse_240();
    check("env_loop15", 32'(dut.decay), 32'd15);
    if1.reg_400C = 8'h00;
    pulse_240();
    pulse_240();
    check("env_13", 32'(dut.decay), 32'd13);
    if1.reg_400F = 8'h08; if1.reg_event = 1; if1.enable_240hz = 1;
    tick(1);
    if1.reg_event = 0; if1.enable_240hz = 0;
    check("env_coincident_start", 32'(dut.start_flag), 32'd1);
    check("env_coincident_decay", 32'(dut.decay), 32'd13);
    pulse_240();
    check("env_coincident_next", 32'(dut.decay), 32'd15);
    if1.reg_400C = 8'h02;
    repeat (4) pulse_240();
    check("env_divider_v2", 32'(dut.decay), 32'd13);
`endif

    // CLK_DIV=3 timer: 15-clk events, period select lands at next reload
    apply_reset();
    wait_event(1'b1, 20, "d3_first", n);
    check("d3_first_latency", n, 32'd3);
    wait_event(1'b1, 40, "d3_int1", n);
    check("d3_interval1", n, 32'd15);
    wait_event(1'b1, 40, "d3_int2", n);
    check("d3_interval2", n, 32'd15);
    if3.reg_400E = 8'h0F;
    wait_event(1'b1, 40, "d3_int3", n);
    check("d3_interval_pending_sel", n, 32'd15);
    wait_event(1'b1, 13000, "d3_int4", n);
    check("d3_interval_sel15", n, 32'd12207);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
